// File: rtl/taptempo_pkg.sv
// Shared tap-tempo constants: BPM limits, timepulse period and the
// derived period-counter sizing used by percount and the BPM divider.
package taptempo_pkg;

    localparam int PULSE_PER_NS = 5120;
    localparam int BPM_MAX      = 250;

    // Shortest beat interval in ns (one minute / BPM_MAX).
    localparam int MIN_NS = (60_000_000 / BPM_MAX) * 1000;

    localparam int BPMPER_MIN      = MIN_NS / PULSE_PER_NS;
    localparam int BPMPER_MAX      = 62_600;
    localparam int BPMPER_REG_SIZE = $clog2(BPMPER_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/risingedge.sv
// Registered rising-edge detector with async active-high reset.
// Ports: clk_i, rst_i, sig_i (level, clk_i-synchronous), rise_o (1 on 0->1).
module risingedge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic low_seen_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q      <= 1'b0;
            low_seen_q <= 1'b0;
        end else begin
            sig_q      <= sig_i;
            low_seen_q <= low_seen_q | ~sig_i;
        end
    end

    // A level already high at reset release is not an edge: require a
    // real low sample first.
    assign rise_o = sig_i & ~sig_q & low_seen_q;

endmodule

// File: rtl/percount.sv
// Tap-period counter: counts timepulses between accepted button taps.
// Ports: clk_i, rst_i, tp_i, btn_i in; btn_per_o, btn_per_ready out.
module percount #(
    parameter int BPMPER_MAX      = taptempo_pkg::BPMPER_MAX,
    parameter int BPMPER_MIN      = taptempo_pkg::BPMPER_MIN,
    parameter int BPMPER_REG_SIZE = $clog2(BPMPER_MAX + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tp_i,
    input  logic                     btn_i,
    output logic [BPMPER_REG_SIZE:0] btn_per_o,
    output logic                     btn_per_ready
);

    import taptempo_pkg::*;

    localparam int W = BPMPER_REG_SIZE;
    localparam logic [W-1:0] CNT_MIN = W'(BPMPER_MIN);
    localparam logic [W-1:0] CNT_MAX = W'(BPMPER_MAX);

    state_e       state_q;
    logic [W-1:0] cnt_q;
    logic [W:0]   per_q;
    logic         rdy_q;
    logic         tap;
    logic [W-1:0] cnt_start;

    risingedge u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (btn_i),
        .rise_o (tap)
    );

    // A timepulse coincident with the tap belongs to the new period.
    assign cnt_start = tp_i ? W'(1) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tap) begin
                        state_q <= COUNT;
                        cnt_q   <= cnt_start;
                    end
                end
                COUNT: begin
                    // Tap wins over a simultaneous timeout.
                    if (tap && cnt_q >= CNT_MIN) begin
                        per_q <= {1'b0, cnt_q};
                        rdy_q <= 1'b1;
                        cnt_q <= cnt_start;
                    end else if (tp_i && cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (tp_i) begin
                        cnt_q <= cnt_q + W'(1);
                    end
                end
            endcase
        end
    end

    assign btn_per_o     = per_q;
    assign btn_per_ready = rdy_q;

endmodule

// File: tb/tb_percount.sv
// Directed bench for percount with MIN=4, MAX=20 and tp every 3 clocks.
// Expected periods are hand-computed tp counts between taps.
module tb_percount;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tp_i  = 1'b0;
    logic       btn_i = 1'b0;
    logic [5:0] btn_per_o;
    logic       btn_per_ready;

    always #5 clk_i = ~clk_i;

    percount #(
        .BPMPER_MIN (4),
        .BPMPER_MAX (20)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tp_i          (tp_i),
        .btn_i         (btn_i),
        .btn_per_o     (btn_per_o),
        .btn_per_ready (btn_per_ready)
    );

    int   errs = 0;
    int   nchk = 0;
    int   ph   = 0;
    int   tps  = 0;
    int   nstb = 0;
    int   dbl  = 0;
    int   snap = 0;
    logic prev_rdy = 1'b0;
    logic last_tp  = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, sample #1 later.
    task automatic cyc(input logic b);
        btn_i   = b;
        tp_i    = (ph == 0);
        last_tp = tp_i;
        if (tp_i) tps++;
        ph = (ph == 2) ? 0 : ph + 1;
        @(posedge clk_i);
        #1;
        if (btn_per_ready) begin
            nstb++;
            if (prev_rdy) dbl++;
        end
        prev_rdy = btn_per_ready;
    endtask

    // Tap cycle; rearm restarts the bench's tp tally like the DUT does.
    task automatic tap(input bit rearm);
        cyc(1'b1);
        if (rearm) tps = last_tp ? 1 : 0;
    endtask

    task automatic gap_to(input int n);
        while (tps < n) cyc(1'b0);
    endtask

    initial begin
        repeat (3) cyc(1'b0);
        chk("reset_per", int'(btn_per_o), 0);
        chk("reset_rdy", int'(btn_per_ready), 0);
        rst_i = 1'b0;
        cyc(1'b0);

        // basic period
        tap(1);
        chk("arm_no_strobe", int'(btn_per_ready), 0);
        gap_to(10);
        tap(1);
        chk("basic_rdy", int'(btn_per_ready), 1);
        chk("basic_per", int'(btn_per_o), 10);
        cyc(1'b0);
        chk("basic_one_cycle", int'(btn_per_ready), 0);
        chk("basic_hold", int'(btn_per_o), 10);

        // too-fast tap is dropped, count keeps running
        gap_to(2);
        tap(0);
        chk("fast_reject", int'(btn_per_ready), 0);
        gap_to(7);
        tap(1);
        chk("fast_rdy", int'(btn_per_ready), 1);
        chk("fast_per", int'(btn_per_o), 7);

        // timeout back to idle
        snap = nstb;
        gap_to(25);
        chk("timeout_no_strobe", nstb, snap);
        chk("timeout_hold", int'(btn_per_o), 7);
        tap(1);
        chk("rearm_no_strobe", int'(btn_per_ready), 0);
        gap_to(6);
        tap(1);
        chk("rearm_rdy", int'(btn_per_ready), 1);
        chk("rearm_per", int'(btn_per_o), 6);

        // tap coincident with tp counts that pulse
        gap_to(25);
        while (ph != 0) cyc(1'b0);
        tap(1);
        chk("coin_arm", int'(btn_per_ready), 0);
        gap_to(8);
        tap(1);
        chk("coin_per", int'(btn_per_o), 8);

        // tap and timeout together: tap wins with MAX
        gap_to(20);
        cyc(1'b0);
        cyc(1'b0);
        tap(1);
        chk("tmo_tap_rdy", int'(btn_per_ready), 1);
        chk("tmo_tap_per", int'(btn_per_o), 20);
        gap_to(5);
        tap(1);
        chk("after_tmo_per", int'(btn_per_o), 5);

        // async reset mid-count, button held across release
        tap(1);
        gap_to(3);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_per", int'(btn_per_o), 0);
        chk("rst_mid_rdy", int'(btn_per_ready), 0);
        cyc(1'b1);
        cyc(1'b1);
        rst_i = 1'b0;
        snap = nstb;
        repeat (18) cyc(1'b1);
        chk("held_no_strobe", nstb, snap);
        cyc(1'b0);
        tap(1);
        chk("held_arm_only", int'(btn_per_ready), 0);
        gap_to(6);
        tap(1);
        chk("held_rdy", int'(btn_per_ready), 1);
        chk("held_per", int'(btn_per_o), 6);
        cyc(1'b0);

        chk("strobe_total", nstb, 7);
        chk("no_back_to_back", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
